// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer: widths, op encodings,
// FSM state encoding and the operand-1 bus formatting helper.
package alu_seq_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned OPND_W = 8;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned TO_W   = 16;

    localparam logic [OP_W-1:0] OP_ADD = 2'b00;
    localparam logic [OP_W-1:0] OP_SUB = 2'b01;
    localparam logic [OP_W-1:0] OP_MUL = 2'b10;
    localparam logic [OP_W-1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        LOAD1 = 3'd2,
        HOLD  = 3'd3,
        LOADM = 3'd4,
        DRAIN = 3'd5,
        RESP  = 3'd6
    } state_t;

    // Division takes the full {A,Q} dividend; all other ops use the low byte.
    function automatic logic [DATA_W-1:0] op1_bus(input logic [OP_W-1:0] op,
                                                  input logic [DATA_W-1:0] x);
        return (op == OP_DIV) ? x : {8'h00, x[OPND_W-1:0]};
    endfunction

endpackage

// File: rtl/alu_seq_cnt.sv
// Loadable 4-bit down-counter with a zero flag; times the HOLD and DRAIN
// phases of the sequencer. Decrement saturates at zero.
module alu_seq_cnt
    import alu_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero_c
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the 8-bit multi-cycle ALU: one op in flight, clear,
// operand sequencing, result capture. Optional LOADM watchdog: ALU_SEQ_TIMEOUT_EN.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 1,
    parameter int unsigned RES_DLY     = 1,
    parameter int unsigned TIMEOUT     = 255
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [DATA_W-1:0] req_x,
    input  logic [OPND_W-1:0] req_y,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [OP_W-1:0]   rsp_op,
    output logic              rsp_err,
    output logic              alu_clr,
    output logic              alu_start,
    output logic [OP_W-1:0]   alu_sel,
    output logic [DATA_W-1:0] alu_inbus,
    input  logic [DATA_W-1:0] alu_outbus,
    input  logic              alu_finish,
    output logic              busy
);

    state_t state, next_state;

    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] x_q;
    logic [OPND_W-1:0] y_q;

    logic              accept_c;
    logic              cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0]  cnt_val;
    logic              capture;
    logic              timeout_c;

    logic              req_ready_d, rsp_valid_d, busy_d;
    logic              alu_clr_d, alu_start_d;
    logic [OP_W-1:0]   alu_sel_d, op_n;
    logic [DATA_W-1:0] alu_inbus_d;

    assign accept_c = (state == IDLE) && req_valid;

    alu_seq_cnt u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_val),
        .zero_c   (cnt_zero)
    );

`ifdef ALU_SEQ_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;

    // Cycles spent in LOADM; cleared whenever the FSM is elsewhere.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (state == LOADM) begin
            to_cnt <= to_cnt + TO_W'(1);
        end else begin
            to_cnt <= '0;
        end
    end

    assign timeout_c = (state == LOADM) && !alu_finish && (to_cnt == TO_W'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TO_W'(TIMEOUT);
    assign timeout_c      = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state plus output decode of the state being entered, so every
    // registered output lines up with the state it belongs to.
    always_comb begin
        next_state  = state;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        cnt_val     = '0;
        capture     = 1'b0;
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        busy_d      = 1'b0;
        alu_clr_d   = 1'b0;
        alu_start_d = 1'b0;
        alu_sel_d   = '0;
        alu_inbus_d = '0;
        op_n        = accept_c ? req_op : op_q;

        case (state)
            IDLE:  if (req_valid) next_state = CLR;
            CLR:   next_state = LOAD1;
            LOAD1: begin
                cnt_load   = 1'b1;
                cnt_val    = CNT_W'(HOLD_CYCLES);
                next_state = HOLD;
            end
            HOLD: begin
                if (cnt_zero) next_state = LOADM;
                else          cnt_dec    = 1'b1;
            end
            LOADM: begin
                if (alu_finish) begin
                    cnt_load   = 1'b1;
                    cnt_val    = CNT_W'(RES_DLY);
                    next_state = DRAIN;
                end else if (timeout_c) begin
                    next_state = RESP;
                end
            end
            DRAIN: begin
                if (cnt_zero) begin
                    capture    = 1'b1;
                    next_state = RESP;
                end else begin
                    cnt_dec    = 1'b1;
                end
            end
            RESP:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase

        req_ready_d = (next_state == IDLE);
        busy_d      = (next_state != IDLE);
        rsp_valid_d = (next_state == RESP);
        alu_clr_d   = (next_state == CLR) || timeout_c;
        alu_start_d = (next_state == LOAD1);

        case (next_state)
            CLR:          alu_sel_d = op_n;
            LOAD1, HOLD: begin
                alu_sel_d   = op_n;
                alu_inbus_d = op1_bus(op_q, x_q);
            end
            LOADM, DRAIN: begin
                alu_sel_d   = op_n;
                alu_inbus_d = {8'h00, y_q};
            end
            default: begin
                alu_sel_d   = '0;
                alu_inbus_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            alu_clr   <= 1'b0;
            alu_start <= 1'b0;
            alu_sel   <= '0;
            alu_inbus <= '0;
        end else begin
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            busy      <= busy_d;
            alu_clr   <= alu_clr_d;
            alu_start <= alu_start_d;
            alu_sel   <= alu_sel_d;
            alu_inbus <= alu_inbus_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q <= '0;
            x_q  <= '0;
            y_q  <= '0;
        end else if (accept_c) begin
            op_q <= req_op;
            x_q  <= req_x;
            y_q  <= req_y;
        end
    end

    // Response payload is written once per op and then held through RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_data <= '0;
            rsp_op   <= '0;
            rsp_err  <= 1'b0;
        end else if (capture) begin
            rsp_data <= alu_outbus;
            rsp_op   <= op_q;
            rsp_err  <= 1'b0;
        end else if (timeout_c) begin
            rsp_data <= '0;
            rsp_op   <= op_q;
            rsp_err  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: behavioural ALU stub on the
// ALU pins, arithmetic reference model, directed and random scenarios.
module tb_alu_cmd_sequencer;

    localparam int unsigned HOLD = 1;
    localparam int unsigned RDLY = 1;
    localparam int unsigned TO   = 40;

    logic        clk, rst;
    logic        req_valid, req_ready;
    logic [1:0]  req_op;
    logic [15:0] req_x;
    logic [7:0]  req_y;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_op;
    logic        rsp_err;
    logic        alu_clr, alu_start;
    logic [1:0]  alu_sel;
    logic [15:0] alu_inbus, alu_outbus;
    logic        alu_finish;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    alu_cmd_sequencer #(.HOLD_CYCLES(HOLD), .RES_DLY(RDLY), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_x(req_x), .req_y(req_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_op(rsp_op), .rsp_err(rsp_err),
        .alu_clr(alu_clr), .alu_start(alu_start), .alu_sel(alu_sel),
        .alu_inbus(alu_inbus), .alu_outbus(alu_outbus), .alu_finish(alu_finish),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arithmetic of the ALU: add/sub/mul on bytes, div gives {rem,quot}.
    function automatic logic [15:0] model(input logic [1:0] op, input logic [15:0] x,
                                          input logic [7:0] y);
        logic [7:0] a;
        a = x[7:0];
        case (op)
            2'b00:   return {8'h00, 8'(a + y)};
            2'b01:   return {8'h00, 8'(a - y)};
            2'b10:   return 16'(16'(a) * 16'(y));
            default: return {8'(x % 16'(y)), 8'(x / 16'(y))};
        endcase
    endfunction

    // ALU stub: latches operand 1 on start, reads M off the bus when it finishes.
    int          stub_extra = 2;
    bit          stub_hang  = 1'b0;
    int          stub_cnt;
    logic [15:0] stub_a;
    logic [1:0]  stub_op;

    always @(posedge clk or posedge rst) begin
        if (rst || alu_clr) begin
            alu_finish <= 1'b0;
            alu_outbus <= 16'h0;
            stub_cnt   <= 0;
        end else if (alu_start) begin
            stub_a   <= alu_inbus;
            stub_op  <= alu_sel;
            stub_cnt <= int'(HOLD) + 4 + stub_extra;
        end else if (stub_cnt > 1) begin
            stub_cnt <= stub_cnt - 1;
        end else if (stub_cnt == 1 && !stub_hang) begin
            alu_outbus <= model(stub_op, stub_a, alu_inbus[7:0]);
            alu_finish <= 1'b1;
            stub_cnt   <= 0;
        end
    end

    // Pin monitor: clear pulses before start, operand-1 bus and its hold length.
    int          clr_seen = 0, clr_pre = 0, starts = 0, hold_cnt = 0, rsp_cycles = 0;
    bit          in_hold = 1'b0;
    logic [15:0] start_bus;
    logic [1:0]  start_sel;

    always @(negedge clk) begin
        if (rsp_valid) rsp_cycles++;
        if (alu_clr) clr_seen++;
        if (alu_start) begin
            start_bus = alu_inbus;
            start_sel = alu_sel;
            clr_pre   = clr_seen;
            clr_seen  = 0;
            hold_cnt  = 0;
            in_hold   = 1'b1;
            starts++;
        end else if (in_hold) begin
            if (alu_inbus == start_bus && busy) hold_cnt++;
            else in_hold = 1'b0;
        end
    end

    task automatic send_req(input logic [1:0] op, input logic [15:0] x, input logic [7:0] y,
                            output bit ok);
        int n = 0;
        req_op = op; req_x = x; req_y = y; req_valid = 1'b1;
        while (!req_ready && n < 100) begin @(posedge clk); #1; n++; end
        ok = req_ready;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output bit ok, output int busy_low);
        int n = 0;
        busy_low = 0;
        while (!rsp_valid && n < 500) begin
            if (!busy) busy_low++;
            @(posedge clk); #1; n++;
        end
        ok = rsp_valid;
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_x = '0; req_y = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        n_checks++; if ({rsp_valid, busy, alu_clr, alu_start} !== 4'b0) begin n_fail++; $display("FAIL reset_ctrl got %b want 0000", {rsp_valid, busy, alu_clr, alu_start}); end
        n_checks++; if ({alu_sel, alu_inbus} !== 18'h0) begin n_fail++; $display("FAIL reset_alu_bus got %h want 0", {alu_sel, alu_inbus}); end
        n_checks++; if ({rsp_data, rsp_op, rsp_err} !== 19'h0) begin n_fail++; $display("FAIL reset_rsp got %h want 0", {rsp_data, rsp_op, rsp_err}); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_op(input logic [1:0] op, input logic [15:0] x, input logic [7:0] y,
                                  input logic [15:0] exp_data, input logic [15:0] exp_bus);
        bit ok;
        int busy_low;
        stub_extra = 2;
        send_req(op, x, y, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL accept_op%0d req_ready stayed low", op); end
        wait_rsp(ok, busy_low);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rsp_wait_op%0d no rsp_valid within bound", op); end
        n_checks++; if (clr_pre !== 1) begin n_fail++; $display("FAIL clr_before_start_op%0d got %0d want 1", op, clr_pre); end
        n_checks++; if (start_bus !== exp_bus) begin n_fail++; $display("FAIL start_inbus_op%0d got %h want %h", op, start_bus, exp_bus); end
        n_checks++; if (start_sel !== op) begin n_fail++; $display("FAIL start_sel_op%0d got %0d want %0d", op, start_sel, op); end
        // Counter loaded with HOLD_CYCLES exits HOLD on zero: HOLD_CYCLES+1 hold cycles.
        n_checks++; if (hold_cnt !== int'(HOLD) + 1) begin n_fail++; $display("FAIL hold_cycles_op%0d got %0d want %0d", op, hold_cnt, HOLD + 1); end
        n_checks++; if (busy_low !== 0) begin n_fail++; $display("FAIL busy_op%0d low for %0d cycles want 0", op, busy_low); end
        n_checks++; if (rsp_data !== exp_data) begin n_fail++; $display("FAIL rsp_data_op%0d got %h want %h", op, rsp_data, exp_data); end
        n_checks++; if (rsp_op !== op || rsp_err !== 1'b0) begin n_fail++; $display("FAIL rsp_op_err_op%0d got %0d/%b want %0d/0", op, rsp_op, rsp_err, op); end
        take_rsp();
        n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL after_handshake_op%0d valid/ready/busy got %b%b%b want 010", op, rsp_valid, req_ready, busy); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int busy_low, bad = 0, starts0;
        logic [15:0] d0;
        stub_extra = 1;
        send_req(2'b10, 16'd40, 8'd12, ok);
        wait_rsp(ok, busy_low);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_first_rsp no rsp_valid"); end
        d0 = rsp_data; starts0 = starts;
        req_op = 2'b01; req_x = 16'd100; req_y = 8'd30; req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_data !== d0 || req_ready !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL bp_stall_stable %0d bad cycles want 0", bad); end
        n_checks++; if (d0 !== 16'd480) begin n_fail++; $display("FAIL bp_first_data got %0d want 480", d0); end
        n_checks++; if (starts !== starts0) begin n_fail++; $display("FAIL bp_no_early_start got %0d starts want %0d", starts, starts0); end
        take_rsp();
        n_checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_req_waits busy/valid got %b%b want 00", busy, rsp_valid); end
        send_req(2'b01, 16'd100, 8'd30, ok);
        wait_rsp(ok, busy_low);
        n_checks++; if (!ok || rsp_data !== 16'd70) begin n_fail++; $display("FAIL bp_second_data got %0d valid %b want 70", rsp_data, ok); end
        take_rsp();
    endtask

    task automatic test_reset_mid_op();
        bit ok;
        int n = 0, rc0;
        stub_extra = 20;
        send_req(2'b00, 16'd40, 8'd12, ok);
        while (!(alu_inbus == 16'd12 && !alu_start) && n < 50) begin @(posedge clk); #1; n++; end
        n_checks++; if (alu_inbus !== 16'd12) begin n_fail++; $display("FAIL rst_mid_reach_loadm inbus got %0d want 12", alu_inbus); end
        @(posedge clk); #1;
        rc0 = rsp_cycles;
        rst = 1'b1;
        #1;
        n_checks++; if ({req_ready, busy, rsp_valid, alu_clr, alu_start} !== 5'b10000) begin n_fail++; $display("FAIL rst_mid_ctrl got %b want 10000", {req_ready, busy, rsp_valid, alu_clr, alu_start}); end
        n_checks++; if ({alu_sel, alu_inbus} !== 18'h0) begin n_fail++; $display("FAIL rst_mid_alu_bus got %h want 0", {alu_sel, alu_inbus}); end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        n_checks++; if (rsp_cycles !== rc0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_rsp rsp cycles %0d busy %b want %0d/0", rsp_cycles - rc0, busy, 0); end
    endtask

    task automatic test_random();
        bit ok;
        int busy_low, bad;
        logic [1:0]  op;
        logic [15:0] x, d0;
        logic [7:0]  y;
        for (int k = 0; k < 14; k++) begin
            op = 2'($urandom_range(0, 3));
            x  = 16'($urandom);
            y  = 8'($urandom_range(0, 255));
            if (op == 2'b11) begin
                y = 8'($urandom_range(1, 255));
                x[15:8] = 8'($urandom_range(0, int'(y) - 1));
            end
            stub_extra = int'($urandom_range(0, 6));
            send_req(op, x, y, ok);
            wait_rsp(ok, busy_low);
            n_checks++; if (!ok || rsp_data !== model(op, x, y)) begin n_fail++; $display("FAIL rand_data[%0d] op %0d got %h want %h", k, op, rsp_data, model(op, x, y)); end
            n_checks++; if (rsp_op !== op || rsp_err !== 1'b0) begin n_fail++; $display("FAIL rand_op_err[%0d] got %0d/%b want %0d/0", k, rsp_op, rsp_err, op); end
            d0 = rsp_data; bad = 0;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
                if (rsp_valid !== 1'b1 || rsp_data !== d0) bad++;
            end
            n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rand_hold[%0d] %0d unstable cycles want 0", k, bad); end
            take_rsp();
        end
    endtask

`ifdef ALU_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int busy_low, n = 0;
        stub_hang = 1'b1;
        send_req(2'b10, 16'd7, 8'd9, ok);
        while (!rsp_valid && n < 500) begin @(posedge clk); #1; n++; end
        n_checks++; if (!rsp_valid || n < int'(TO)) begin n_fail++; $display("FAIL timeout_delay after %0d cycles valid %b want >= %0d", n, rsp_valid, TO); end
        n_checks++; if (rsp_err !== 1'b1 || rsp_data !== 16'h0) begin n_fail++; $display("FAIL timeout_rsp err/data got %b/%h want 1/0000", rsp_err, rsp_data); end
        n_checks++; if (clr_seen !== 1) begin n_fail++; $display("FAIL timeout_clr got %0d pulses want 1", clr_seen); end
        take_rsp();
        stub_hang = 1'b0;
        wait_rsp(ok, busy_low);
    endtask
`endif

    initial begin
        test_reset();
        test_single_op(2'b00, 16'd40,    8'd12,  16'd52,    16'd40);
        test_single_op(2'b01, 16'd40,    8'd12,  16'd28,    16'd40);
        test_single_op(2'b10, 16'd40,    8'd12,  16'd480,   16'd40);
        test_single_op(2'b11, 16'd11542, 8'd135, 16'd17237, 16'd11542);
        test_backpressure();
        test_reset_mid_op();
        test_random();
`ifdef ALU_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
